apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the APB bus; owns psel/penable/pwrite/paddr/pwdata on behalf of the ports.
- Requester 0 is the CPU port, requester 1 the DMA/test port; round-robin grant, one transfer in flight.
- Decodes the slave select (2'b01 slave 1, 2'b10 slave 2 / UART) from an address bit and runs the IDLE→SETUP→ACCESS sequence, waiting on pready.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
SLV_BIT, 24, paddr bit selecting slave: 0 → Psel 2'b01, 1 → Psel 2'b10
TIMEOUT_CYC, 255, ACCESS wait limit (used only with APB_TIMEOUT_EN); 8-bit counter

Ports:
pclk  in  1  clock; all logic on rising edge
Reset  in  1  synchronous, active-low reset
req  in  2  per-requester transfer request; level, held until done
wr  in  2  per-requester direction, 1 = write
addr0 / addr1  in  ADDR_W  requester addresses
wdata0 / wdata1  in  DATA_W  requester write data
done  out  2  one-cycle completion pulse to the granted requester
rdata  out  DATA_W  read data, valid while done is high
err  out  1  transfer error, valid while done is high
Psel  out  2  one-hot slave select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pready  in  1  slave ready
prdata  in  DATA_W  slave read data
pslverr  in  1  slave error

Behaviour:
- All outputs are registered. While Reset=0 at an edge, the following clear: state=IDLE, Psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, done=0, rdata=0, err=0, last=1 (requester 0 wins the first tie).
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - No request: stay in IDLE with Psel=0 and penable=0.
  - Exactly one req bit set: grant that requester.
  - Both set: grant ~last.
  - On the grant edge: latch gnt, last←gnt, paddr/pwdata/pwrite from the granted port, and Psel from paddr[SLV_BIT]; go to SETUP.
- SETUP: Psel held, penable=0, for exactly one cycle; next state ACCESS with penable=1.
- ACCESS:
  - Psel, penable, paddr, pwrite, pwdata are held stable.
  - On an edge where pready=1: done[gnt]←1 for one cycle, err←pslverr, rdata←prdata on reads or 0 on writes. Psel←0, penable←0, state→IDLE.
- Minimum latency: request sampled at edge N → SETUP visible after N, ACCESS after N+1, done after N+2 if pready is already high.
- Every transfer returns to IDLE, so there is at least one idle cycle between transfers. This is the point where the other requester can win.
- Requester inputs are ignored outside IDLE; an addr/wr change mid-transfer has no effect.
- A req dropped mid-transfer does not abort the transfer; done still pulses.
- A req still high in the cycle done pulses is a new request; it is arbitrated normally on the next IDLE edge.
- Fairness: with both requests continuously high, grants alternate 0,1,0,1.
- Reset asserted in SETUP or ACCESS aborts immediately: the bus goes idle next edge and no done is issued.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments every ACCESS cycle with pready=0.
  - On reaching TIMEOUT_CYC: done[gnt]←1, err←1, rdata←0, bus released, state→IDLE.
  - A pready seen on the same edge as the limit wins; it completes normally.
- Not defined: no counter; ACCESS waits for pready indefinitely.

Test Plan:
- Reset=0 for 2 cycles, then 1 with req=0 → Psel=0, penable=0, done=0 held for 10 cycles.
- req=2'b01, wr0=1, addr0=32'h00000010, wdata0=32'hCAFE0001, pready=1 → Psel=01 one cycle with penable=0, then penable=1; pwdata=CAFE0001; done=2'b01 two edges after grant; err=0.
- req=2'b10, wr1=0, addr1=32'h01111111, pready low 3 ACCESS cycles then high with prdata=32'hDEAD2023 → Psel=10, pwrite=0, bus stable across wait states, done=2'b10, rdata=DEAD2023.
- req=2'b11 held for 4 transfers, pready=1 → grant order 0,1,0,1; IDLE cycle between each; pslverr=1 on the third transfer → err=1 only with that done.
- Reset=0 mid-ACCESS → bus idle next edge, no done; after release a pending req=2'b01 restarts from SETUP.
- APB_TIMEOUT_EN, TIMEOUT_CYC=8, pready stuck 0 → done pulses after 8 ACCESS cycles with err=1, rdata=0; without the macro → still in ACCESS after 300 cycles.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter driving an APB master sequence (IDLE -> SETUP -> ACCESS).
// Define APB_TIMEOUT_EN to bound the ACCESS wait to TIMEOUT_CYC cycles (8-bit counter).
module apb_req_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SLV_BIT     = 24,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              pclk,
    input  logic              Reset,
    input  logic [1:0]        req,
    input  logic [1:0]        wr,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [1:0]        Psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic [1:0]          psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [1:0]          done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                pick;
    logic [ADDR_W-1:0]   sel_addr;
`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0]          tmo_q, tmo_d;
`endif

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        done_d    = 2'b00;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef APB_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        // A tie goes to whoever did not win last time.
        pick     = (req == 2'b11) ? ~last_q : req[1];
        sel_addr = pick ? addr1 : addr0;

        case (state_q)
            IDLE: begin
                psel_d    = 2'b00;
                penable_d = 1'b0;
                if (req != 2'b00) begin
                    gnt_d    = pick;
                    last_d   = pick;
                    paddr_d  = sel_addr;
                    pwdata_d = pick ? wdata1 : wdata0;
                    pwrite_d = wr[pick];
                    psel_d   = sel_addr[SLV_BIT] ? 2'b10 : 2'b01;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_d     = 8'd0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    done_d    = gnt_q ? 2'b10 : 2'b01;
                    err_d     = pslverr;
                    rdata_d   = pwrite_q ? '0 : prdata;
                    psel_d    = 2'b00;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    done_d    = gnt_q ? 2'b10 : 2'b01;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    psel_d    = 2'b00;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            psel_q    <= 2'b00;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done_q    <= 2'b00;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
`ifdef APB_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign done    = done_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign Psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level model of grant order, slave decode and completion data.
module tb_apb_req_arbiter;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int SLV_BIT     = 24;
    localparam int TIMEOUT_CYC = 8;

    logic              pclk = 1'b0;
    logic              Reset;
    logic [1:0]        req, wr;
    logic [ADDR_W-1:0] addr0, addr1, paddr;
    logic [DATA_W-1:0] wdata0, wdata1, rdata, pwdata, prdata;
    logic [1:0]        done, Psel;
    logic              err, penable, pwrite, pready, pslverr;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_last = 1;   // model: requester that won the previous grant

    always #5 pclk = ~pclk;

    apb_req_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SLV_BIT(SLV_BIT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .pclk(pclk), .Reset(Reset), .req(req), .wr(wr),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done(done), .rdata(rdata), .err(err), .Psel(Psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    // Round-robin rule: single request wins outright, a tie goes to the one that lost last time.
    function automatic int pick(input logic [1:0] r, input int last);
        if (r == 2'b11) return 1 - last;
        return r[1] ? 1 : 0;
    endfunction

    task automatic run_xfer(input logic [1:0] r, input logic [1:0] w,
                            input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                            input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                            input int waits, input logic [DATA_W-1:0] rd, input logic se);
        int                g;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed, er;
        logic              ew;
        logic [1:0]        es, edone;
        req = r; wr = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        pready = 1'b0; pslverr = 1'b0;
        g = pick(r, exp_last);
        exp_last = g;
        ea = g ? a1 : a0;
        ed = g ? d1 : d0;
        ew = w[g];
        es = ea[SLV_BIT] ? 2'b10 : 2'b01;
        edone = g ? 2'b10 : 2'b01;
        er = ew ? '0 : rd;

        @(negedge pclk);
        n_checks++;
        if ({Psel, penable, pwrite, paddr, pwdata, done} !== {es, 1'b0, ew, ea, ed, 2'b00}) begin
            n_fail++;
            $display("FAIL setup: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h done=%b, want psel=%b pen=0 pwr=%b paddr=%h pwdata=%h done=00",
                     Psel, penable, pwrite, paddr, pwdata, done, es, ew, ea, ed);
        end
        // Requester-side churn while busy must not reach the bus.
        req = 2'($urandom); wr = 2'($urandom);
        addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;

        @(negedge pclk);
        n_checks++;
        if ({Psel, penable, pwrite, paddr, pwdata, done} !== {es, 1'b1, ew, ea, ed, 2'b00}) begin
            n_fail++;
            $display("FAIL access_entry: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h done=%b, want psel=%b pen=1 pwr=%b paddr=%h pwdata=%h done=00",
                     Psel, penable, pwrite, paddr, pwdata, done, es, ew, ea, ed);
        end

        for (int i = 0; i <= waits; i++) begin
            pready  = (i == waits);
            prdata  = (i == waits) ? rd : $urandom;
            pslverr = (i == waits) ? se : 1'($urandom);
            @(negedge pclk);
            n_checks++;
            if (i < waits) begin
                if ({Psel, penable, pwrite, paddr, pwdata, done} !== {es, 1'b1, ew, ea, ed, 2'b00}) begin
                    n_fail++;
                    $display("FAIL wait_state: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h done=%b, want psel=%b pen=1 pwr=%b paddr=%h pwdata=%h done=00",
                             Psel, penable, pwrite, paddr, pwdata, done, es, ew, ea, ed);
                end
            end else begin
                if ({Psel, penable, done, err, rdata} !== {2'b00, 1'b0, edone, se, er}) begin
                    n_fail++;
                    $display("FAIL complete: got psel=%b pen=%b done=%b err=%b rdata=%h, want psel=00 pen=0 done=%b err=%b rdata=%h",
                             Psel, penable, done, err, rdata, edone, se, er);
                end
            end
        end
        pready = 1'b0; pslverr = 1'b0; req = 2'b00;
    endtask

    task automatic test_reset();
        Reset = 1'b0; req = 2'b00; wr = 2'b00; addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
        repeat (2) @(negedge pclk);
        n_checks++;
        if ({Psel, penable, pwrite, paddr, pwdata, done, rdata, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h done=%b rdata=%h err=%b, want all zero",
                     Psel, penable, pwrite, paddr, pwdata, done, rdata, err);
        end
        exp_last = 1;
    endtask

    task automatic test_idle();
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            n_checks++;
            if ({Psel, penable, done} !== 5'b0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got psel=%b pen=%b done=%b, want 00/0/00", i, Psel, penable, done);
            end
        end
    endtask

    task automatic test_write();
        run_xfer(2'b01, 2'b01, 32'h0000_0010, 32'h0, 32'hCAFE_0001, 32'h0, 0, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_read_wait();
        run_xfer(2'b10, 2'b00, 32'h0, 32'h0111_1111, 32'h0, 32'h0, 3, 32'hDEAD_2023, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_xfer(2'b11, 2'($urandom), $urandom, $urandom, $urandom, $urandom, 0, $urandom, (i == 2));
    endtask

    task automatic test_abort();
        req = 2'b01; wr = 2'b00; addr0 = 32'h0000_0100; pready = 1'b0;
        repeat (2) @(negedge pclk);
        n_checks++;
        if ({Psel, penable} !== 3'b011) begin
            n_fail++;
            $display("FAIL abort_pre: got psel=%b pen=%b, want 01/1", Psel, penable);
        end
        Reset = 1'b0;
        @(negedge pclk);
        exp_last = 1;
        n_checks++;
        if ({Psel, penable, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got psel=%b pen=%b done=%b, want 00/0/00", Psel, penable, done);
        end
        Reset = 1'b1;
        run_xfer(2'b01, 2'b00, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 1, 32'hA5A5_0F0F, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_xfer(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom, $urandom,
                     $urandom, $urandom_range(0, 3), $urandom, 1'($urandom));
    endtask

    task automatic test_timeout();
        bit stray;
        int g;
        req = 2'b01; wr = 2'b00; addr0 = 32'h0100_0040; pready = 1'b0; prdata = $urandom;
        g = pick(2'b01, exp_last);
        exp_last = g;
        repeat (2) @(negedge pclk);
        req = 2'b00;
`ifdef APB_TIMEOUT_EN
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            @(negedge pclk);
            n_checks++;
            if (k < TIMEOUT_CYC) begin
                if ({done, penable} !== 3'b001) begin
                    n_fail++;
                    $display("FAIL timeout_wait%0d: got done=%b pen=%b, want 00/1", k, done, penable);
                end
            end else if ({done, err, rdata, Psel, penable} !== {2'b01, 1'b1, 32'h0, 2'b00, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_done: got done=%b err=%b rdata=%h psel=%b pen=%b, want 01/1/0/00/0",
                         done, err, rdata, Psel, penable);
            end
        end
`else
        stray = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge pclk);
            if (done !== 2'b00) stray = 1'b1;
        end
        n_checks++;
        if ({stray, Psel, penable} !== {1'b0, 2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL no_timeout: got stray_done=%b psel=%b pen=%b, want 0/10/1", stray, Psel, penable);
        end
        Reset = 1'b0;
        @(negedge pclk);
        Reset = 1'b1;
        exp_last = 1;
`endif
    endtask

    initial begin
        test_reset();
        test_idle();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_abort();
        test_random();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
